// File: rtl/pc_hazard_ctrl.sv
// pc_hazard_ctrl: next-PC select plus RAW-stall and branch-flush control for a 5-stage pipeline
module pc_hazard_ctrl #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 3,
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] pc_i,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic             id_rs1_en_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs2_en_i,
    input  logic [4:0]       id_rd_addr_i,
    input  logic             id_rd_wren_i,
    input  logic             ex_br_taken_i,
    input  logic [WIDTH-1:0] ex_br_target_i,
    output logic [WIDTH-1:0] next_pc_o,
    output logic             pc_hold_o,
    output logic             if_id_stall_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    localparam int HZ = DEPTH - WB_BYPASS;
    logic [DEPTH-1:0]      sb_v_q, sb_v_d;
    logic [DEPTH-1:0][4:0] sb_rd_q, sb_rd_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic                  hazard, redirect, issue;
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < HZ; k++)
            hazard = hazard | (sb_v_q[k] &&
                ((id_rs1_en_i && id_rs1_addr_i != 5'd0 && id_rs1_addr_i == sb_rd_q[k]) ||
                 (id_rs2_en_i && id_rs2_addr_i != 5'd0 && id_rs2_addr_i == sb_rd_q[k])));
        hazard   = hazard && id_valid_i;
        redirect = ex_br_taken_i;
        issue    = id_valid_i && !hazard && !redirect;
        sb_v_d     = sb_v_q;
        sb_rd_d    = sb_rd_q;
        sb_v_d[0]  = issue && id_rd_wren_i && id_rd_addr_i != 5'd0;
        sb_rd_d[0] = issue ? id_rd_addr_i : 5'd0;
        for (int k = 1; k < DEPTH; k++) begin
            sb_v_d[k]  = sb_v_q[k-1];
            sb_rd_d[k] = sb_rd_q[k-1];
        end
        stall_cnt_d   = stall_cnt_q + CNT_W'(hazard && !redirect && stall_cnt_q != '1);
        flush_cnt_d   = flush_cnt_q + CNT_W'(redirect && flush_cnt_q != '1);
        next_pc_o     = (redirect && !rst_i) ? ex_br_target_i : pc_i + WIDTH'(4);
        pc_hold_o     = !rst_i && !redirect && hazard;
        if_id_stall_o = !rst_i && !redirect && hazard;
        if_id_flush_o = rst_i || redirect;
        id_ex_flush_o = rst_i || redirect || hazard;
        stall_cnt_o   = stall_cnt_q;
        flush_cnt_o   = flush_cnt_q;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sb_v_q      <= '0;
            sb_rd_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_v_q      <= sb_v_d;
            sb_rd_q     <= sb_rd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule
